// File: rtl/priority_decoder_3b4.sv
// priority_decoder_3b4
//   Turns a stream of 3-bit priority codes back into one-hot 4-bit line vectors.
//   Codes arrive over a valid/ready handshake. Each decoded vector goes into a
//   2-entry FIFO and is presented downstream over valid/ready.
//   Null codes (0) and illegal codes (5..7) are consumed without being forwarded.
//   Illegal codes are also counted.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   Z          input code: 0 none, 1..4 line index + 1, 5..7 illegal
//   in_valid   Z is presented this cycle
//   in_ready   block can accept Z this cycle
//   w          one-hot vector at the FIFO head (0 when empty)
//   out_valid  w holds a decoded vector
//   out_ready  downstream consumes w this cycle
//   err        sticky flag: an illegal code has been accepted since reset
//   err_count  number of illegal codes accepted, saturating
//   dec_count  number of vectors pushed into the FIFO, wrapping
module priority_decoder_3b4 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       Z,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  occ_e state_q, state_d;

  logic [3:0]       mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic             err_q;
  logic [CNT_W-1:0] err_count_q, dec_count_q;

  logic       accept, push, pop;
  logic       code_legal, code_illegal;
  logic [3:0] dec_vec;

  // Decode the incoming code. Z=0 is neither legal nor illegal: it is simply dropped.
  always_comb begin
    dec_vec      = 4'b0000;
    code_legal   = 1'b0;
    code_illegal = 1'b0;
    case (Z)
      3'd1:    begin dec_vec = 4'b0001; code_legal = 1'b1; end
      3'd2:    begin dec_vec = 4'b0010; code_legal = 1'b1; end
      3'd3:    begin dec_vec = 4'b0100; code_legal = 1'b1; end
      3'd4:    begin dec_vec = 4'b1000; code_legal = 1'b1; end
      3'd0:    ;
      default: code_illegal = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && code_legal;
  assign pop    = out_valid && out_ready;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state. A push together with a pop leaves the occupancy unchanged.
  // pop is never true in StEmpty, because out_valid is low there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push)         state_d = StOne;
      StOne:   if (push && !pop) state_d = StFull;
               else if (pop && !push) state_d = StEmpty;
      StFull:  if (pop && !push) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Outputs. in_ready depends combinationally only on out_ready.
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StFull) || out_ready;
    w         = out_valid ? mem_q[rd_ptr_q] : 4'b0000;
  end

  // FIFO storage and pointers. When full, a push with a pop writes into the slot
  // being vacated by the pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q[0] <= 4'b0000;
      mem_q[1] <= 4'b0000;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dec_vec;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Status counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
      dec_count_q <= '0;
    end else begin
      if (accept && code_illegal) begin
        err_q <= 1'b1;
        if (err_count_q != {CNT_W{1'b1}}) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
      if (push) begin
        dec_count_q <= dec_count_q + 1'b1;
      end
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;
  assign dec_count = dec_count_q;

endmodule

// File: tb/tb_priority_decoder_3b4.sv
module tb_priority_decoder_3b4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] Z;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready, out_valid, err;
  logic [3:0] w;
  logic [7:0] err_count, dec_count;

  logic       in_ready2, out_valid2, err2;
  logic [3:0] w2;
  logic [1:0] err_count2, dec_count2;

  always #5 clk = ~clk;

  priority_decoder_3b4 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Z         (Z),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_count (err_count),
    .dec_count (dec_count)
  );

  // Narrow-counter instance, driven by the same stimulus, for the saturation and wrap cases.
  priority_decoder_3b4 #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .Z         (Z),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .w         (w2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .err       (err2),
    .err_count (err_count2),
    .dec_count (dec_count2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of pending vectors plus plain integer counters.
  logic [3:0] q[$];
  bit         m_err;
  int         m_errc8, m_errc2, m_decc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_w;
    exp_w = (q.size() > 0) ? q[0] : 4'b0000;
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("w", {28'd0, w}, {28'd0, exp_w});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("err_count", {24'd0, err_count}, m_errc8);
    check("dec_count", {24'd0, dec_count}, m_decc % 256);
    check("w_n", {28'd0, w2}, {28'd0, exp_w});
    check("err_count_n", {30'd0, err_count2}, m_errc2);
    check("dec_count_n", {30'd0, dec_count2}, m_decc % 4);
  endtask

  // Applies one cycle of stimulus, advances the model at the edge and checks the result.
  task automatic step(input logic [2:0] z, input logic iv, input logic ordy, input logic rn);
    bit exp_rdy, acc, pop_m;
    Z         = z;
    in_valid  = iv;
    out_ready = ordy;
    reset_n   = rn;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("in_ready_n", {31'd0, in_ready2}, {31'd0, exp_rdy});
    acc   = iv && exp_rdy;
    pop_m = (q.size() > 0) && ordy;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_err = 0; m_errc8 = 0; m_errc2 = 0; m_decc = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (acc && z >= 1 && z <= 4) begin
        q.push_back(4'(1 << (z - 1)));
        m_decc++;
      end
      if (acc && z >= 5) begin
        m_err = 1;
        if (m_errc8 < 255) m_errc8++;
        if (m_errc2 < 3) m_errc2++;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    m_err = 0; m_errc8 = 0; m_errc2 = 0; m_decc = 0;
    Z = 3'd0; in_valid = 1'b0; out_ready = 1'b0; reset_n = 1'b0;
    @(posedge clk);
    #1;
    step(3'd0, 1'b0, 1'b0, 1'b0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single decode with out_ready high
    step(3'd3, 1'b1, 1'b1, 1'b1);
    check("z3_w", {28'd0, w}, 32'h4);
    step(3'd0, 1'b0, 1'b1, 1'b1);
    check("z3_dec", {24'd0, dec_count}, 32'd1);

    // Fill while stalled, then drain in order
    step(3'd1, 1'b1, 1'b0, 1'b1);
    step(3'd4, 1'b1, 1'b0, 1'b1);
    check("full_rdy", {31'd0, in_ready}, 32'd0);
    check("full_head", {28'd0, w}, 32'h1);
    // Full with a simultaneous pop and push
    step(3'd2, 1'b1, 1'b1, 1'b1);
    check("pp_head", {28'd0, w}, 32'h8);
    step(3'd0, 1'b0, 1'b1, 1'b1);
    step(3'd0, 1'b0, 1'b1, 1'b1);

    // Null and illegal codes
    step(3'd0, 1'b1, 1'b1, 1'b1);
    step(3'd6, 1'b1, 1'b1, 1'b1);
    check("ill_err", {31'd0, err}, 32'd1);

    // Saturate the narrow error counter and wrap the narrow decode counter
    for (int i = 0; i < 5; i++) step(3'(5 + (i % 3)), 1'b1, 1'b1, 1'b1);
    check("sat_n", {30'd0, err_count2}, 32'd3);
    for (int i = 0; i < 4; i++) step(3'd2, 1'b1, 1'b1, 1'b1);
    step(3'd0, 1'b0, 1'b1, 1'b1);

    // Reset while full with err set
    step(3'd1, 1'b1, 1'b0, 1'b1);
    step(3'd2, 1'b1, 1'b0, 1'b1);
    step(3'd3, 1'b1, 1'b1, 1'b0);
    check("rst_cnt", {24'd0, err_count}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 299) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
